// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and defaults for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_e;

  localparam int BURST_MAX_DEF    = 8;
  localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter in front of the single-port data memory
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int BURST_MAX    = BURST_MAX_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_last,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);

  arb_state_e    state, stateNext;
  logic [SW-1:0] starveCnt, starveNext;
  logic [BW-1:0] beatCnt, beatNext;
  logic          cpuGnt, dmaGnt;

  // Grant decision and memory-side mux; an idle bus still presents the CPU address.
  always_comb begin
    cpuGnt = 1'b0;
    dmaGnt = 1'b0;
    if (state == ARB_BURST) begin
      dmaGnt = dma_req;
    end else if (dma_req && starveCnt == SW'(STARVE_LIMIT)) begin
      dmaGnt = 1'b1;
    end else if (cpu_req) begin
      cpuGnt = 1'b1;
    end else begin
      dmaGnt = dma_req;
    end
    mem_a     = dmaGnt ? dma_addr : cpu_addr;
    mem_wd    = dmaGnt ? dma_wdata : cpu_wdata;
    mem_we    = (cpuGnt & cpu_we) | (dmaGnt & dma_we);
    cpu_stall = cpu_req & ~cpuGnt;
    dma_gnt   = dmaGnt;
  end

  assign cpu_rdata = mem_rd;

  always_comb begin
    stateNext = state;
    beatNext  = beatCnt;
    case (state)
      ARB_IDLE: begin
        if (dmaGnt && !dma_last && BURST_MAX > 1) begin
          stateNext = ARB_BURST;
          beatNext  = BW'(1);
        end
      end
      ARB_BURST: begin
        if (!dma_req || (dmaGnt && (dma_last || beatCnt == BW'(BURST_MAX - 1)))) begin
          stateNext = ARB_IDLE;
          beatNext  = '0;
        end else if (dmaGnt) begin
          beatNext = beatCnt + BW'(1);
        end
      end
      default: begin
        stateNext = ARB_IDLE;
        beatNext  = '0;
      end
    endcase

    // A forced release leaves the count at zero, so DMA must starve again to win.
    if (dma_req && !dmaGnt) begin
      starveNext = (starveCnt == SW'(STARVE_LIMIT)) ? starveCnt : starveCnt + SW'(1);
    end else begin
      starveNext = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      starveCnt  <= '0;
      beatCnt    <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      state      <= stateNext;
      starveCnt  <= starveNext;
      beatCnt    <= beatNext;
      dma_rvalid <= dmaGnt & ~dma_we;
      if (dmaGnt && !dma_we) begin
        dma_rdata <= mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter against a behavioural model
module tb_dmem_arbiter;

  localparam int SLIM = 4;
  localparam int BMAX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0, dma_last = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;
  logic [31:0] cpu_rdata, dma_rdata, mem_a, mem_wd, mem_rd;
  logic        cpu_stall, dma_gnt, dma_rvalid, mem_we;

  dmem_arbiter #(.AW(32), .DW(32), .BURST_MAX(BMAX), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Data memory the arbiter drives: 16 words, combinational read, synchronous write.
  logic [31:0] memArr [16] = '{default: '0};
  assign mem_rd = memArr[mem_a[5:2]];
  always @(posedge clk) begin
    if (mem_we) memArr[mem_a[5:2]] <= mem_wd;
  end

  typedef struct {
    logic        stall;
    logic        dgnt;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        rv;
    logic [31:0] rdat;
  } exp_t;

  exp_t expQ[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: beats taken in the current burst (0 = arbitrating) and denied-cycle run.
  int          burstLen = 0;
  int          waitCnt = 0;
  logic        lastRv = 1'b0;
  logic [31:0] lastRd = '0;
  logic [31:0] refMem [16] = '{default: '0};
  bit          cpuHeld = 1'b0;
  bit          dmaHeld = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r,
                      input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwd,
                      input logic dreq, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd,
                      input logic dlast);
    exp_t e;
    logic cWin, dWin;
    @(posedge clk);
    #1;
    rst = r;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd; dma_last = dlast;
    if (!r) begin
      burstLen = 0; waitCnt = 0; lastRv = 1'b0; lastRd = '0;
    end
    if (burstLen > 0) begin
      dWin = dreq;
      cWin = 1'b0;
    end else begin
      dWin = dreq && (waitCnt >= SLIM || !creq);
      cWin = creq && !dWin;
    end
    e.stall = creq && !cWin;
    e.dgnt  = dWin;
    e.we    = (cWin && cwe) || (dWin && dwe);
    e.a     = dWin ? daddr : caddr;
    e.wd    = dWin ? dwd : cwd;
    e.rd    = refMem[e.a[5:2]];
    e.rv    = lastRv;
    e.rdat  = lastRd;
    expQ.push_back(e);
    if (e.we) refMem[e.a[5:2]] = e.wd;
    if (r) begin
      lastRv = dWin && !dwe;
      if (lastRv) lastRd = e.rd;
      if (dWin) begin
        waitCnt = 0;
        burstLen++;
        if (dlast || burstLen >= BMAX) burstLen = 0;
      end else begin
        if (!dreq) burstLen = 0;
        waitCnt = dreq ? ((waitCnt < SLIM) ? waitCnt + 1 : SLIM) : 0;
      end
    end
    cpuHeld = creq && !cWin;
    dmaHeld = dreq && !dWin;
  endtask

  task automatic rndStep();
    logic        creq, cwe, dreq, dwe, dl;
    logic [31:0] ca, cd, da, dd;
    if (cpuHeld) begin
      creq = cpu_req; cwe = cpu_we; ca = cpu_addr; cd = cpu_wdata;
    end else begin
      creq = ($urandom_range(0, 99) < 55);
      cwe  = 1'($urandom_range(0, 1));
      ca   = $urandom;
      cd   = $urandom;
    end
    if (dmaHeld) begin
      dreq = dma_req; dwe = dma_we; da = dma_addr; dd = dma_wdata; dl = dma_last;
    end else begin
      dreq = ($urandom_range(0, 99) < 70);
      dwe  = 1'($urandom_range(0, 1));
      da   = $urandom;
      dd   = $urandom;
      dl   = ($urandom_range(0, 99) < 20);
    end
    step(1'b1, creq, cwe, ca, cd, dreq, dwe, da, dd, dl);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("cpu_stall",  32'(cpu_stall),  32'(e.stall));
        chk("dma_gnt",    32'(dma_gnt),    32'(e.dgnt));
        chk("mem_we",     32'(mem_we),     32'(e.we));
        chk("mem_a",      mem_a,           e.a);
        chk("mem_wd",     mem_wd,          e.wd);
        chk("cpu_rdata",  cpu_rdata,       e.rd);
        chk("dma_rvalid", 32'(dma_rvalid), 32'(e.rv));
        chk("dma_rdata",  dma_rdata,       e.rdat);
      end
    end
  end

  initial begin : stimulus
    logic [31:0] da;
    // Reset with both requests pending, then release: CPU first.
    repeat (2) step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    // CPU store then load of the same word.
    step(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    // Seed the burst region, then a 3-beat DMA read with the CPU arriving on beat 2.
    step(1'b1, 1'b1, 1'b1, 32'h24, 32'h24242424, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h28, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    // Persistent contention: DMA single beat wins after the starvation limit.
    repeat (7) step(1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b1, 32'h30, 32'hC0FFEE00, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    // Endless burst with CPU always asking: forced release, then starvation regrant.
    da = 32'h100;
    for (int i = 0; i < 22; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 1'b1, da, da ^ 32'h5A5A0000, 1'b0);
      if (!dmaHeld) da = da + 32'h4;
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    // Reset landing on beat 2 of a read burst, then the CPU goes straight through.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h18, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h18, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cpuHeld = 1'b0;
    dmaHeld = 1'b0;
    repeat (2000) rndStep();
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the Memory-stage load/store path (CPU port) and a DMA/debug loader port (DMA port).
- Sits between the Memory stage and the data memory: all memory address, write-data and write-enable lines pass through it.
- CPU has default priority. DMA bursts are atomic up to a cap. A starvation counter guarantees DMA progress.
- While the CPU port is denied, it raises cpu_stall so the pipeline freezes.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- BURST_MAX, 8, maximum DMA beats per burst before forced release (>=1).
- STARVE_LIMIT, 4, number of consecutive denied DMA-request cycles after which DMA wins over CPU (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- cpu_req  in  1  Memory stage needs a memory access this cycle (load or store)
- cpu_we  in  1  store
- cpu_addr  in  AW  byte address (ALU result)
- cpu_wdata  in  DW  store data
- cpu_rdata  out  DW  load data, combinational from mem_rd
- cpu_stall  out  1  CPU request not served this cycle
- dma_req  in  1  DMA beat request
- dma_we  in  1  DMA write
- dma_addr  in  AW  DMA address
- dma_wdata  in  DW  DMA write data
- dma_last  in  1  final beat of burst
- dma_gnt  out  1  DMA beat accepted this cycle
- dma_rvalid  out  1  registered: read data of the previous granted DMA read beat is valid
- dma_rdata  out  DW  registered DMA read data
- mem_a  out  AW  to data memory
- mem_wd  out  DW  to data memory
- mem_we  out  1  to data memory (synchronous write)
- mem_rd  in  DW  from data memory (combinational read)

Behaviour:

Reset (rst=0, asynchronous):
- State goes to IDLE; starve_cnt=0; beat_cnt=0; dma_rvalid=0; dma_rdata=0.
- Combinational outputs then resolve under IDLE rules.
- Reset mid-burst aborts the burst; no write is in flight after reset.

Per-cycle grant (combinational from state, counters and requests). Exactly one of cpu_gnt/dma_gnt is asserted, or neither.
- IDLE:
  - If dma_req and starve_cnt==STARVE_LIMIT, grant DMA.
  - Else if cpu_req, grant CPU.
  - Else if dma_req, grant DMA.
- BURST: grant DMA if dma_req; CPU is never granted in BURST.

Outputs and stall:
- cpu_stall = cpu_req & ~cpu_gnt.
- Mux: mem_a/mem_wd follow the granted port. With no grant, mem_a=cpu_addr and mem_wd=cpu_wdata.
- mem_we = (cpu_gnt & cpu_we) | (dma_gnt & dma_we); it is never 1 without a grant.
- cpu_rdata = mem_rd, always. The pipeline samples it only when cpu_req & ~cpu_stall.

State transitions (at clk edge):
- IDLE -> BURST when dma_gnt and !dma_last and BURST_MAX>1; beat_cnt <= 1.
- BURST -> IDLE when any of:
  - dma_req=0 (DMA abandoning the burst ends it);
  - dma_gnt & dma_last;
  - dma_gnt & beat_cnt==BURST_MAX-1 (forced release).
- Otherwise in BURST, beat_cnt increments on each dma_gnt.
- A forced release does not set priority. DMA re-competes in IDLE and normally loses to a pending CPU request until it starves again.

Starvation counter:
- starve_cnt increments (saturating at STARVE_LIMIT) when dma_req & ~dma_gnt.
- It clears on any dma_gnt, or when dma_req=0.

DMA read return:
- dma_rvalid <= dma_gnt & ~dma_we.
- dma_rdata <= mem_rd when (dma_gnt & ~dma_we), else it holds. Latency is 1 cycle.

Boundary conditions:
- cpu_req and dma_req both arriving in IDLE with starve_cnt<STARVE_LIMIT: CPU wins.
- Both asserted and the DMA request persists: DMA wins after STARVE_LIMIT denied cycles.
- Request inputs are expected to be held stable while they are denied.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - the state typedef enum {ARB_IDLE, ARB_BURST};
  - the default constants for BURST_MAX and STARVE_LIMIT.
- Single module; no sub-module needed.
- The grant mux is kept as one always_comb block.

Test Plan:
1. Reset (rst=0 with dma_req=1, cpu_req=1) -> dma_rvalid=0, dma_rdata=0. Once rst=1, CPU is granted first cycle: cpu_stall=0, mem_a=cpu_addr.
2. CPU store alone (cpu_req=1, cpu_we=1, addr=0x10, wdata=0xDEADBEEF) -> mem_we=1, mem_a=0x10, cpu_stall=0. A following CPU load of 0x10 returns 0xDEADBEEF same cycle.
3. DMA 3-beat read burst at 0x20/0x24/0x28 (dma_last on beat 3), cpu_req raised at beat 2 -> dma_gnt for 3 consecutive cycles, cpu_stall=1 during beats 2-3, dma_rvalid pulses one cycle after each beat with matching data. CPU is granted in the cycle after beat 3.
4. Continuous cpu_req plus dma_req with STARVE_LIMIT=4 -> DMA denied 4 cycles, granted on the 5th, cpu_stall=1 exactly that cycle, starve_cnt back to 0.
5. DMA burst of 10 beats with BURST_MAX=8, dma_last never asserted, cpu_req=1 throughout -> 8 grants, then forced release to IDLE and CPU granted. DMA is regranted after starving STARVE_LIMIT cycles.
6. Reset asserted mid-burst at beat 2 -> state IDLE immediately, dma_rvalid=0, no mem_we. After release, the CPU request is served with no stall.
